jk_seq_ctrl: RTL

Sequencing controller for a bank of WIDTH JK flip-flop cells that together form a loadable up/down counter. The controller captures a start value, limit and direction on a start request. Each cycle it computes the J/K drive for every cell, so the bank loads, counts toward the limit, holds on request and reports completion. It sits between a requesting control block and the JK-cell datapath; the cells are instantiated internally.

---
 rtl/jk_seq_pkg.sv | 45 ++++
 rtl/jk_cell.sv | 42 ++++
 rtl/jk_seq_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jk_seq_pkg                                                 |
// | Purpose : Shared types, JK command encodings and the toggle-enable   |
// |           helper used by the JK-cell counter sequencing controller.  |
// | Contents: state_t   - controller state enumeration                   |
// |           JK_*      - {J,K} command encodings for one cell           |
// |           MAX_W     - widest supported counter                       |
// |           lower_all_set() - carry-chain term for one counter bit     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package jk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    localparam int MAX_W = 16;

    // Toggle enable for bit idx of a binary counter. The caller passes Q
    // when counting up and Qbar when counting down, so "all lower bits
    // are 1" covers both directions. Bit 0 has no lower bits and always
    // toggles.
    function automatic logic lower_all_set(input logic [MAX_W-1:0] src,
                                           input int               idx);
        logic all_set;
        all_set = 1'b1;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < idx) begin
                all_set = all_set & src[b];
            end
        end
        return all_set;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jk_cell                                                    |
// | Purpose : Single JK flip-flop, rising edge, async active-high reset  |
// |           to Q=0 / Qbar=1.                                           |
// | Ports   : clk, rst - clock and asynchronous reset                    |
// |           j, k     - 00 hold, 01 clear, 10 set, 11 toggle            |
// |           q, qbar  - stored bit and its complement                   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: r_q <= r_q;
                JK_CLR:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                JK_TOG:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/jk_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jk_seq_ctrl                                                |
// | Purpose : Sequencer driving a bank of WIDTH JK cells as a loadable   |
// |           up/down counter: load, count to a limit, hold, report done.|
// | Ports   : clk, rst        - clock, async active-high reset           |
// |           start           - run request (sampled in IDLE only)       |
// |           dir             - 1 up / 0 down (captured with start)      |
// |           load_val, limit - start and terminal count (captured)      |
// |           hold            - freeze count while running               |
// |           busy, done      - activity flag, one-cycle completion pulse|
// |           count           - Q outputs of the cell bank               |
// |           j_bus, k_bus    - J/K drive currently applied to the cells |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j_bus,
    output logic [WIDTH-1:0] k_bus
);

    state_t           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_limit;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_src;
    logic [MAX_W-1:0] w_src_ext;
    logic [WIDTH-1:0] w_tog;
    logic             w_at_limit;

    // Counting down toggles a bit when all lower bits are 0, i.e. when all
    // lower Qbar bits are 1, so the same carry chain serves both directions.
    assign w_src      = r_dir ? count : w_qbar;
    assign w_src_ext  = MAX_W'(w_src);
    assign w_at_limit = (count == r_limit);

    for (genvar g = 0; g < WIDTH; g++) begin : g_cells
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (w_j[g]),
            .k    (w_k[g]),
            .q    (count[g]),
            .qbar (w_qbar[g])
        );
        assign w_tog[g] = lower_all_set(w_src_ext, g);
    end

    // Cell drive: only LOAD and an unheld, not-yet-finished RUN cycle move
    // the bank; everything else issues hold to every cell.
    always_comb begin
        w_j = '0;
        w_k = '0;
        case (r_state)
            LOAD: begin
                w_j = r_load;
                w_k = ~r_load;
            end
            RUN: begin
                if (!w_at_limit && !hold) begin
                    w_j = w_tog;
                    w_k = w_tog;
                end
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    // busy/done are registered alongside the state so they change on the
    // same edge as the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_load  <= '0;
            r_limit <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dir   <= dir;
                        r_load  <= load_val;
                        r_limit <= limit;
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_at_limit) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign j_bus = w_j;
    assign k_bus = w_k;

endmodule
`default_nettype wire
